mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
//  Synthesizable main-memory controller on the CPU external bus. Latches the
//  address on astb, runs batch (auto-increment) and atomic read-modify-write
//  transfers, and drives a 1-cycle synchronous tagged SRAM. Serves the service
//  registers at the top of the address space: syndrome, last-address latch and
//  ECC mode. Sits directly downstream of cpu (o_ad/o_tag/strobes in, i_data/i_tag out).
// PARAMETERS
//  AW  20  word address width; service regs at 2^AW-1, 2^AW-2, 2^AW-3
//  DW  64  data word width
//  TW   8  tag width
// PORTS
//  clk         in   1   clock; all state changes on rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  bus_ad      in   DW  address (astb) / write data (wr) from cpu o_ad
//  bus_tag     in   TW  write tag from cpu o_tag
//  bus_astb    in   1   address strobe
//  bus_atomic  in   1   RMW flag: hold address, no increment
//  bus_rd      in   1   read request
//  bus_wr      in   1   write request
//  rd_data     out  DW  read data to cpu i_data
//  rd_tag      out  TW  read tag to cpu i_tag
//  ram_en      out  1   SRAM cycle enable (combinational)
//  ram_we      out  1   SRAM write enable (combinational)
//  ram_addr    out  AW  SRAM address = current waddr
//  ram_wdata   out  DW  = bus_ad;  ram_wtag out TW = bus_tag
//  ram_rdata   in   DW  SRAM read data, valid after the edge that sampled ram_en
//  ram_rtag    in   TW  SRAM read tag, same timing
//  rmw_busy    out  1   registered; high while in RMW state
//  bus_err     out  1   registered 1-cycle pulse: rd/wr with no address latched
// BEHAVIOUR
//  Reset: waddr=0, laddr=0, ecc_mode=0, state=IDLE, rd_sel=RAM, hold regs 0,
//   rd_data=0, rd_tag=0, rmw_busy=0, bus_err=0. Abandons any transfer in flight.
//  Priority per cycle: astb > wr > rd; others ignored that cycle.
//  astb: laddr<=waddr; waddr<=bus_ad[AW-1:0]; state<=ADDR (also from RMW: lock dropped).
//  wr, waddr<2^AW-3: ram_en=ram_we=1; waddr<=waddr+1 unless bus_atomic.
//  wr to 2^AW-3: ecc_mode<=bus_ad[3:0]; no RAM cycle, no increment.
//  wr to 2^AW-1 / 2^AW-2: ignored, no increment.
//  rd, waddr<2^AW-3: ram_en=1, ram_we=0; rd_sel<=RAM; waddr<=waddr+1 unless atomic.
//  rd 2^AW-1: hold<={0,0} (no Hamming syndrome). rd 2^AW-2: hold<={laddr zero-ext,0}.
//   rd 2^AW-3: hold<={ecc_mode zero-ext,0}. Special reads: rd_sel<=HOLD, no increment.
//  Latency: rd_data/rd_tag valid in cycle after rd; stable until next rd
//   (mux of ram_rdata/hold by registered rd_sel; SRAM output changes only on ram_en).
//  Increment wraps mod 2^AW; from 2^AW-4 waddr steps into service region.
//  FSM: IDLE -(astb)-> ADDR; ADDR -(rd&atomic)-> RMW; RMW -(wr)-> ADDR (write
//   to same waddr, increments only if atomic now low); RMW -(astb)-> ADDR;
//   RMW -(rd)-> RMW (re-read, same addr). rmw_busy = (state==RMW).
//  IDLE + rd/wr: access performed at waddr (0), bus_err=1 next cycle, state stays IDLE.
//  Simultaneous rd&wr: write only. Reset mid-batch: next access needs a new astb.
// TESTING
//  astb 0x00100; wr D0,D1,D2 tags 1,2,3; astb 0x00100; rd x3 -> D0,D1,D2 tags 1,2,3, each 1 cycle after rd.
//  astb 0x00200; rd atomic -> rmw_busy=1; wr atomic 0xABCD -> rmw_busy=0; rd -> 0xABCD, waddr 0x200 then 0x201.
//  astb 0x00300; astb 0xFFFFE; rd -> rd_data=0x300; rd again -> 0x300 (no increment); rd 0xFFFFF -> 0.
//  astb 0xFFFFD; wr 0x5 -> rd 0xFFFFD returns 5; astb 0xFFFFC; wr X; rd -> reads ecc_mode (waddr stepped to 0xFFFFD).
//  After reset, rd with no astb -> bus_err pulses 1 cycle, rd_data=mem[0]; assert reset_n low mid-batch -> all outputs 0 async.
//  rd and wr same cycle at 0x00400 -> write happens, rd_data unchanged, waddr 0x401.

Source files
------------

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: CPU external bus between cpu and the main-memory controller.
//  bus_ad      address (with bus_astb) or write data (with bus_wr)
//  bus_tag     write tag
//  bus_astb    address strobe
//  bus_atomic  read-modify-write flag: hold address, no increment
//  bus_rd      read request
//  bus_wr      write request
//  rd_data     read data back to cpu, valid the cycle after bus_rd
//  rd_tag      read tag back to cpu
//  rmw_busy    controller is holding a read-modify-write lock
//  bus_err     1-cycle pulse: rd/wr issued with no address latched
interface mem_bus_ctrl_if #(
    parameter int DW = 64,
    parameter int TW = 8
);
    logic [DW-1:0] bus_ad;
    logic [TW-1:0] bus_tag;
    logic          bus_astb;
    logic          bus_atomic;
    logic          bus_rd;
    logic          bus_wr;
    logic [DW-1:0] rd_data;
    logic [TW-1:0] rd_tag;
    logic          rmw_busy;
    logic          bus_err;

    modport master (
        output bus_ad, bus_tag, bus_astb, bus_atomic, bus_rd, bus_wr,
        input  rd_data, rd_tag, rmw_busy, bus_err
    );

    modport slave (
        input  bus_ad, bus_tag, bus_astb, bus_atomic, bus_rd, bus_wr,
        output rd_data, rd_tag, rmw_busy, bus_err
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: main-memory controller driving a 1-cycle synchronous tagged SRAM,
// with batch auto-increment, atomic read-modify-write and three service registers
// (syndrome, last-address latch, ECC mode) at the top of the address space.
//  clk        clock, rising edge
//  reset_n    asynchronous active-low reset
//  bus        CPU bus, slave side (address/data/strobes in, read data/status out)
//  ram_en     SRAM cycle enable (combinational)
//  ram_we     SRAM write enable (combinational)
//  ram_addr   SRAM address = current word address
//  ram_wdata  SRAM write data = bus_ad
//  ram_wtag   SRAM write tag = bus_tag
//  ram_rdata  SRAM read data, valid after the edge that sampled ram_en
//  ram_rtag   SRAM read tag, same timing
module mem_bus_ctrl #(
    parameter int AW = 20,
    parameter int DW = 64,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_bus_ctrl_if.slave bus,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic [TW-1:0] ram_wtag,
    input  logic [DW-1:0] ram_rdata,
    input  logic [TW-1:0] ram_rtag
);
    // RMW is bit 1 alone so rmw_busy comes straight off a flop
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ADDR = 2'b01;
    localparam logic [1:0] RMW  = 2'b10;

    localparam logic [AW-1:0] SYN_A = '1;
    localparam logic [AW-1:0] LAT_A = SYN_A - AW'(1);
    localparam logic [AW-1:0] ECC_A = SYN_A - AW'(2);

    logic [1:0]    state;
    logic [AW-1:0] waddr;
    logic [AW-1:0] laddr;
    logic [3:0]    ecc_mode;
    logic [DW-1:0] hold_data;
    logic          rd_sel;
    logic          rd_vld;
    logic          do_wr;
    logic          do_rd;
    logic          norm;
    logic          inc;

    // astb wins over wr, wr wins over rd
    assign do_wr     = !bus.bus_astb && bus.bus_wr;
    assign do_rd     = !bus.bus_astb && !bus.bus_wr && bus.bus_rd;
    assign norm      = waddr < ECC_A;
    assign ram_en    = (do_wr || do_rd) && norm;
    assign ram_we    = do_wr && norm;
    assign ram_addr  = waddr;
    assign ram_wdata = bus.bus_ad;
    assign ram_wtag  = bus.bus_tag;
    // a re-read inside the RMW lock stays on the locked address
    assign inc       = ram_en && !bus.bus_atomic && !(do_rd && state == RMW);

    // rd_vld keeps the read port at zero until the first read after reset
    assign bus.rd_data  = !rd_vld ? '0 : rd_sel ? hold_data : ram_rdata;
    assign bus.rd_tag   = (!rd_vld || rd_sel) ? '0 : ram_rtag;
    assign bus.rmw_busy = state[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            waddr       <= '0;
            laddr       <= '0;
            ecc_mode    <= '0;
            hold_data   <= '0;
            rd_sel      <= 1'b0;
            rd_vld      <= 1'b0;
            bus.bus_err <= 1'b0;
        end else begin
            bus.bus_err <= (do_wr || do_rd) && state == IDLE;
            if (bus.bus_astb) begin
                laddr <= waddr;
                waddr <= bus.bus_ad[AW-1:0];
                state <= ADDR;
            end else begin
                if (inc)
                    waddr <= waddr + AW'(1);
                if (do_wr && waddr == ECC_A)
                    ecc_mode <= bus.bus_ad[3:0];
                if (do_rd) begin
                    rd_vld    <= 1'b1;
                    rd_sel    <= !norm;
                    hold_data <= waddr == LAT_A ? DW'(laddr) :
                                 waddr == ECC_A ? DW'(ecc_mode) : '0;
                end
                if (state == ADDR && do_rd && bus.bus_atomic)
                    state <= RMW;
                else if (state == RMW && do_wr)
                    state <= ADDR;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed bench for mem_bus_ctrl with a tagged SRAM model and a
// read scoreboard (expected read words queued at issue, popped when rd_data is due).
module tb_mem_bus_ctrl;
    localparam int AW = 20;
    localparam int DW = 64;
    localparam int TW = 8;
    localparam int XW = DW + TW;

    localparam logic [DW-1:0] D0 = 64'h1111_2222_3333_4444;
    localparam logic [DW-1:0] D1 = 64'h5555_6666_7777_8888;
    localparam logic [DW-1:0] D2 = 64'h9999_AAAA_BBBB_CCCC;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [TW-1:0] ram_wtag, ram_rtag;

    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.DW(DW), .TW(TW)) bus ();

    mem_bus_ctrl #(.AW(AW), .DW(DW), .TW(TW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wtag  (ram_wtag),
        .ram_rdata (ram_rdata),
        .ram_rtag  (ram_rtag)
    );

    // 1-cycle synchronous SRAM; output register only moves on read cycles
    logic [XW-1:0] mem [logic [AW-1:0]];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                mem[ram_addr] = {ram_wdata, ram_wtag};
            else
                {ram_rdata, ram_rtag} <= mem.exists(ram_addr) ? mem[ram_addr] : '0;
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    logic [XW-1:0] sb [$];

    task automatic check(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic a, input logic w, input logic r, input logic at,
                       input logic [DW-1:0] ad, input logic [TW-1:0] tg);
        @(negedge clk);
        bus.bus_astb   = a;
        bus.bus_wr     = w;
        bus.bus_rd     = r;
        bus.bus_atomic = at;
        bus.bus_ad     = ad;
        bus.bus_tag    = tg;
        @(posedge clk);
        #1;
        bus.bus_astb   = 1'b0;
        bus.bus_wr     = 1'b0;
        bus.bus_rd     = 1'b0;
        bus.bus_atomic = 1'b0;
        bus.bus_ad     = '0;
        bus.bus_tag    = '0;
    endtask

    task automatic astb(input logic [DW-1:0] ad);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, ad, '0);
    endtask

    task automatic wr(input logic at, input logic [DW-1:0] d, input logic [TW-1:0] t);
        cyc(1'b0, 1'b1, 1'b0, at, d, t);
    endtask

    task automatic rd(input logic at, input logic [DW-1:0] ed, input logic [TW-1:0] et,
                      input string tag);
        logic [XW-1:0] e;
        sb.push_back({ed, et});
        cyc(1'b0, 1'b0, 1'b1, at, '0, '0);
        e = sb.pop_front();
        check(tag, {bus.rd_data, bus.rd_tag}, e);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.bus_astb   = 1'b0;
        bus.bus_wr     = 1'b0;
        bus.bus_rd     = 1'b0;
        bus.bus_atomic = 1'b0;
        bus.bus_ad     = '0;
        bus.bus_tag    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd", {bus.rd_data, bus.rd_tag}, '0);
        check("reset_rmw_busy", bus.rmw_busy, 0);
        check("reset_bus_err", bus.bus_err, 0);
        check("reset_addr", ram_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // batch write then batch read
        astb(64'h100);
        wr(1'b0, D0, 8'd1);
        wr(1'b0, D1, 8'd2);
        wr(1'b0, D2, 8'd3);
        check("batch_wr_addr", ram_addr, 20'h00103);
        check("batch_no_err", bus.bus_err, 0);
        astb(64'h100);
        rd(1'b0, D0, 8'd1, "batch_rd0");
        rd(1'b0, D1, 8'd2, "batch_rd1");
        rd(1'b0, D2, 8'd3, "batch_rd2");
        idle();
        check("rd_hold_stable", {bus.rd_data, bus.rd_tag}, {D2, 8'd3});

        // atomic read-modify-write
        astb(64'h200);
        rd(1'b1, '0, '0, "rmw_rd");
        check("rmw_busy_set", bus.rmw_busy, 1);
        check("rmw_addr_held", ram_addr, 20'h00200);
        rd(1'b0, '0, '0, "rmw_reread");
        check("rmw_reread_busy", bus.rmw_busy, 1);
        check("rmw_reread_addr", ram_addr, 20'h00200);
        wr(1'b1, 64'hABCD, 8'd5);
        check("rmw_busy_clr", bus.rmw_busy, 0);
        check("rmw_wr_addr", ram_addr, 20'h00200);
        rd(1'b0, 64'hABCD, 8'd5, "rmw_result");
        check("rmw_post_addr", ram_addr, 20'h00201);

        // last-address latch and syndrome
        astb(64'h300);
        astb(64'hFFFFE);
        rd(1'b0, 64'h300, '0, "laddr");
        rd(1'b0, 64'h300, '0, "laddr_again");
        check("svc_no_inc", ram_addr, 20'hFFFFE);
        astb(64'hFFFFF);
        rd(1'b0, '0, '0, "syndrome");

        // ECC mode register, stepping into the service region, 4-bit truncation
        astb(64'hFFFFD);
        wr(1'b0, 64'h5, '0);
        check("ecc_wr_no_inc", ram_addr, 20'hFFFFD);
        rd(1'b0, 64'h5, '0, "ecc_mode");
        astb(64'hFFFFC);
        wr(1'b0, 64'h77, 8'd9);
        check("step_into_svc", ram_addr, 20'hFFFFD);
        rd(1'b0, 64'h5, '0, "ecc_after_step");
        wr(1'b0, 64'h1F, '0);
        rd(1'b0, 64'hF, '0, "ecc_4bit");

        // simultaneous rd and wr: write only
        astb(64'h400);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'h1234, 8'd7);
        check("rdwr_no_read", {bus.rd_data, bus.rd_tag}, {64'hF, 8'd0});
        check("rdwr_addr", ram_addr, 20'h00401);
        astb(64'h400);
        rd(1'b0, 64'h1234, 8'd7, "rdwr_data");

        // asynchronous reset in the middle of an RMW
        astb(64'h100);
        rd(1'b1, D0, 8'd1, "pre_reset_rd");
        check("pre_reset_busy", bus.rmw_busy, 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_rd", {bus.rd_data, bus.rd_tag}, '0);
        check("async_rst_busy", bus.rmw_busy, 0);
        check("async_rst_err", bus.bus_err, 0);
        check("async_rst_addr", ram_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // access with no address latched
        wr(1'b0, 64'hBEEF, 8'h11);
        check("idle_wr_err", bus.bus_err, 1);
        idle();
        check("err_one_cycle", bus.bus_err, 0);
        pulse_reset();
        rd(1'b0, 64'hBEEF, 8'h11, "idle_rd_mem0");
        check("idle_rd_err", bus.bus_err, 1);
        check("idle_stays_idle", bus.rmw_busy, 0);
        idle();
        check("idle_rd_err_clr", bus.bus_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
